dct_block_scheduler: RTL

Shares one forward-DCT row-matrix pipeline between up to N block requesters (e.g. Y, Cb, Cr buffers). Arbitrates whole 8x8 blocks, reads the granted requester's rows through a 1-cycle-latency read port, and streams them back-to-back into the DCT with sob/eob/sof framing. A small tag FIFO labels each block returning from the DCT/IDCT chain with its source component.

---
 rtl/dct_pkg.sv | 17 +
 rtl/dct_tag_fifo.sv | 52 +++++
 rtl/dct_block_scheduler.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/dct_pkg.sv
// Shared types for the DCT block scheduler.
// Row payload, component index and scheduler state encoding.
package dct_pkg;

  localparam int BLOCK_ROWS = 8;
  localparam int MAX_REQ    = 4;

  typedef logic [7:0][7:0] row_t;
  typedef logic [$clog2(MAX_REQ)-1:0] comp_t;
  typedef logic [$clog2(BLOCK_ROWS)-1:0] row_idx_t;

  typedef enum logic {
    S_IDLE,
    S_STREAM
  } sched_state_t;

endpackage

// File: rtl/dct_tag_fifo.sv
// Synchronous tag FIFO labelling blocks in flight through the DCT chain.
// Push when not full, pop when not empty; both may happen in one cycle.
module dct_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      unique case (1'b1)
        (do_push & ~do_pop): cnt <= cnt + (AW+1)'(1);
        (do_pop & ~do_push): cnt <= cnt - (AW+1)'(1);
        default:             cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/dct_block_scheduler.sv
// Arbitrates whole 8x8 blocks onto one shared DCT row pipeline.
// Define DCT_SCHED_PRIO_EN for fixed priority instead of round-robin.
module dct_block_scheduler
  import dct_pkg::*;
#(
  parameter int N_REQ     = 3,
  parameter int TAG_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ-1:0]           req_sof,
  output logic [N_REQ-1:0]           grant,
  output logic [2:0]                 rd_row,
  output logic                       rd_en,
  input  row_t [N_REQ-1:0]           rd_data,
  output logic [N_REQ-1:0]           done,
  output logic                       dct_valid,
  output logic                       dct_sob,
  output logic                       dct_eob,
  output logic                       dct_sof,
  output row_t                       dct_data,
  input  logic                       res_valid,
  input  logic                       res_sob,
  output logic [$clog2(N_REQ)-1:0]   res_comp,
  output logic                       res_tag_valid,
  output logic                       tag_err
);

  sched_state_t     state;
  comp_t            win;
  comp_t            win_q;
  comp_t            out_win;
  comp_t            head;
  logic [N_REQ-1:0] win_oh;
  logic             any_req;
  logic             start;
  logic             sof_q;
  logic             out_sof;
  row_idx_t         out_row;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;

`ifndef DCT_SCHED_PRIO_EN
  comp_t last_q;
`endif

  // Descending scan so the closest candidate is the last one written.
  always_comb begin
    win     = '0;
    any_req = 1'b0;
`ifdef DCT_SCHED_PRIO_EN
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[comp_t'(i)]) begin
        win     = comp_t'(i);
        any_req = 1'b1;
      end
    end
`else
    for (int i = N_REQ; i >= 1; i--) begin
      if (req[comp_t'((int'(last_q) + i) % N_REQ)]) begin
        win     = comp_t'((int'(last_q) + i) % N_REQ);
        any_req = 1'b1;
      end
    end
`endif
  end

  always_comb begin
    win_oh = '0;
    for (int i = 0; i < N_REQ; i++) begin
      win_oh[i] = (comp_t'(i) == win);
    end
  end

  assign start = (state == S_IDLE) && any_req && !fifo_full;
  assign pop   = res_valid & res_sob;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      grant  <= '0;
      rd_en  <= 1'b0;
      rd_row <= '0;
      done   <= '0;
      win_q  <= '0;
      sof_q  <= 1'b0;
`ifndef DCT_SCHED_PRIO_EN
      last_q <= comp_t'(N_REQ - 1);
`endif
    end else begin
      done <= '0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_STREAM;
            grant  <= win_oh;
            win_q  <= win;
            sof_q  <= req_sof[win];
            rd_en  <= 1'b1;
            rd_row <= '0;
`ifndef DCT_SCHED_PRIO_EN
            last_q <= win;
`endif
          end
        end
        S_STREAM: begin
          if (rd_row == 3'(BLOCK_ROWS - 1)) begin
            state  <= S_IDLE;
            grant  <= '0;
            rd_en  <= 1'b0;
            rd_row <= '0;
          end else begin
            rd_row <= rd_row + 3'd1;
            if (rd_row == 3'(BLOCK_ROWS - 2)) done <= grant;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output stage tracks the read port one cycle behind rd_en.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dct_valid <= 1'b0;
      out_row   <= '0;
      out_win   <= '0;
      out_sof   <= 1'b0;
    end else begin
      dct_valid <= rd_en;
      out_row   <= rd_row;
      out_win   <= win_q;
      out_sof   <= sof_q;
    end
  end

  assign dct_sob  = dct_valid && (out_row == '0);
  assign dct_eob  = dct_valid && (out_row == row_idx_t'(BLOCK_ROWS - 1));
  assign dct_sof  = dct_sob && out_sof;
  assign dct_data = dct_valid ? rd_data[out_win] : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_err <= 1'b0;
    end else if (pop && fifo_empty) begin
      tag_err <= 1'b1;
    end
  end

  dct_tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .W     ($bits(comp_t))
  ) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (start),
    .din   (win),
    .pop   (pop),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign res_tag_valid = !fifo_empty;
  assign res_comp      = fifo_empty ? '0 : head[$clog2(N_REQ)-1:0];

endmodule
